fetch_sequencer: RTL and testbench

- Upstream stage of the 7-bit-in / 13-bit-out microcode decode ROM (Rom_2).
- Holds the program counter, the fetch register (instruction and operand nibbles), the two-phase sequencer and the C/Z flag register.
- Presents the decode address {instr[3:0], c_flag, z_flag, phase} every cycle.
- Decoded control bits (pc load/increment, flag write) return to this block to close the fetch/execute loop.

---
 rtl/nibbler_pkg.sv | 25 ++
 rtl/pc_counter.sv | 35 +++
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared definitions for the nibbler fetch/decode pipeline.
// Provides the sequencer phase encoding, the decode-address field layout
// and the default program counter / program byte widths.
package nibbler_pkg;

  // Two-phase sequencer state, stored in the phase register.
  typedef enum logic {
    PHASE_FETCH = 1'b0,
    PHASE_EXEC  = 1'b1
  } phase_t;

  // Bit positions inside the 7-bit decode address sent to the control ROM.
  localparam int INSTR_MSB = 6;
  localparam int INSTR_LSB = 3;
  localparam int C_BIT     = 2;
  localparam int Z_BIT     = 1;
  localparam int PHASE_BIT = 0;

  localparam int DECODE_ADDR_WIDTH = 7;

  // Default widths for the program counter and the program memory byte.
  localparam int DEFAULT_PC_WIDTH   = 12;
  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: synchronous reset, enable, load-over-increment.
// Latency: one cycle from enabled edge to new count; no combinational paths.
// No backpressure: the count simply holds while en is low.
//
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   en           - qualifies every update; low means hold
//   load, inc    - load takes priority over inc; neither means hold
//   load_val     - value taken when load is applied
//   count        - current counter value (wraps modulo 2^WIDTH)
module pc_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_val;
      end else if (inc) begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage ahead of the microcode decode ROM: PC, fetch register, phase FSM, C/Z flags.
// Latency: program byte sampled in FETCH shows on instr/oprnd/decode_addr one cycle later.
// No backpressure: enable low freezes every register; control inputs are then ignored.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   enable              - advance the sequencer
//   prog_byte           - program memory data at address pc ({instr, oprnd})
//   load_pc, inc_pc     - control-word PC jump / skip, honoured in EXEC only
//   load_addr           - jump target
//   flags_we, c_in, z_in- control-word flag write and ALU flags, honoured in EXEC only
//   pc                  - program memory address
//   instr, oprnd        - fetched opcode / operand nibbles
//   phase               - 0 = FETCH, 1 = EXEC
//   c_flag, z_flag      - registered carry / zero flags
//   decode_addr         - {instr, c_flag, z_flag, phase}, registers only
module fetch_sequencer
  import nibbler_pkg::*;
#(
  parameter int PC_WIDTH   = DEFAULT_PC_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [DATA_WIDTH-1:0]        prog_byte,
  input  logic                         load_pc,
  input  logic                         inc_pc,
  input  logic [PC_WIDTH-1:0]          load_addr,
  input  logic                         flags_we,
  input  logic                         c_in,
  input  logic                         z_in,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [3:0]                   instr,
  output logic [3:0]                   oprnd,
  output logic                         phase,
  output logic                         c_flag,
  output logic                         z_flag,
  output logic [DECODE_ADDR_WIDTH-1:0] decode_addr
);

  phase_t phase_q;
  logic   in_exec;
  logic   pc_load;
  logic   pc_inc;

  assign in_exec = (phase_q == PHASE_EXEC);

  // Gating with the phase keeps X on the control word in FETCH out of the
  // counter: 0 && X is 0 and 1 || X is 1.
  assign pc_load = in_exec && load_pc;
  assign pc_inc  = !in_exec || inc_pc;

  pc_counter #(
    .WIDTH (PC_WIDTH)
  ) u_pc_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (enable),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (load_addr),
    .count    (pc)
  );

  // Phase FSM, fetch register and flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PHASE_FETCH;
      instr   <= 4'h0;
      oprnd   <= 4'h0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
    end else if (enable) begin
      case (phase_q)
        PHASE_FETCH: begin
          instr   <= prog_byte[DATA_WIDTH-1 -: 4];
          oprnd   <= prog_byte[3:0];
          phase_q <= PHASE_EXEC;
        end
        PHASE_EXEC: begin
          if (flags_we) begin
            c_flag <= c_in;
            z_flag <= z_in;
          end
          phase_q <= PHASE_FETCH;
        end
        default: phase_q <= PHASE_FETCH;
      endcase
    end
  end

  assign phase = phase_q;

  // Built purely from registers so the ROM address never sees input glitches.
  assign decode_addr[INSTR_MSB:INSTR_LSB] = instr;
  assign decode_addr[C_BIT]               = c_flag;
  assign decode_addr[Z_BIT]               = z_flag;
  assign decode_addr[PHASE_BIT]           = phase;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  prog_byte;
  logic        load_pc;
  logic        inc_pc;
  logic [11:0] load_addr;
  logic        flags_we;
  logic        c_in;
  logic        z_in;
  logic [11:0] pc;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic        phase;
  logic        c_flag;
  logic        z_flag;
  logic [6:0]  decode_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_WIDTH   (12),
    .DATA_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .prog_byte   (prog_byte),
    .load_pc     (load_pc),
    .inc_pc      (inc_pc),
    .load_addr   (load_addr),
    .flags_we    (flags_we),
    .c_in        (c_in),
    .z_in        (z_in),
    .pc          (pc),
    .instr       (instr),
    .oprnd       (oprnd),
    .phase       (phase),
    .c_flag      (c_flag),
    .z_flag      (z_flag),
    .decode_addr (decode_addr)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  pb;
    logic        lpc;
    logic        ipc;
    logic [11:0] la;
    logic        fwe;
    logic        ci;
    logic        zi;
    logic [11:0] e_pc;
    logic [3:0]  e_ins;
    logic [3:0]  e_op;
    logic        e_ph;
    logic        e_c;
    logic        e_z;
    logic [6:0]  e_dec;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [11:0] e_pc, input logic [3:0] e_ins,
                           input logic [3:0] e_op, input logic e_ph, input logic e_c,
                           input logic e_z, input logic [6:0] e_dec);
    chk({tag, ".pc"},          32'(pc),          32'(e_pc));
    chk({tag, ".instr"},       32'(instr),       32'(e_ins));
    chk({tag, ".oprnd"},       32'(oprnd),       32'(e_op));
    chk({tag, ".phase"},       32'(phase),       32'(e_ph));
    chk({tag, ".c_flag"},      32'(c_flag),      32'(e_c));
    chk({tag, ".z_flag"},      32'(z_flag),      32'(e_z));
    chk({tag, ".decode_addr"}, 32'(decode_addr), 32'(e_dec));
  endtask

  task automatic drive(input logic rst, input logic en, input logic [7:0] pb, input logic lpc,
                       input logic ipc, input logic [11:0] la, input logic fwe,
                       input logic ci, input logic zi);
    reset     = rst;
    enable    = en;
    prog_byte = pb;
    load_pc   = lpc;
    inc_pc    = ipc;
    load_addr = la;
    flags_we  = fwe;
    c_in      = ci;
    z_in      = zi;
  endtask

  initial begin
    //            rst  en   pb     lpc  ipc  la       fwe  ci   zi    pc       ins   op    ph   c    z    dec
    vecs[0]  = '{1'b1,1'b0,8'h00, 1'b0,1'b0,12'h000, 1'b0,1'b0,1'b0, 12'h000,4'h0, 4'h0, 1'b0,1'b0,1'b0,7'b0000000};
    vecs[1]  = '{1'b0,1'b1,8'hA5, 1'b0,1'b0,12'h000, 1'b0,1'b0,1'b0, 12'h001,4'hA, 4'h5, 1'b1,1'b0,1'b0,7'b1010001};
    vecs[2]  = '{1'b0,1'b1,8'h00, 1'b1,1'b1,12'h3C0, 1'b0,1'b0,1'b0, 12'h3C0,4'hA, 4'h5, 1'b0,1'b0,1'b0,7'b1010000};
    vecs[3]  = '{1'b0,1'b1,8'h3C, 1'b1,1'b0,12'h123, 1'b1,1'b1,1'b1, 12'h3C1,4'h3, 4'hC, 1'b1,1'b0,1'b0,7'b0011001};
    vecs[4]  = '{1'b0,1'b1,8'hFF, 1'b0,1'b0,12'h000, 1'b1,1'b1,1'b0, 12'h3C1,4'h3, 4'hC, 1'b0,1'b1,1'b0,7'b0011100};
    vecs[5]  = '{1'b0,1'b1,8'h7E, 1'b0,1'b0,12'h000, 1'b0,1'b0,1'b1, 12'h3C2,4'h7, 4'hE, 1'b1,1'b1,1'b0,7'b0111101};
    vecs[6]  = '{1'b0,1'b1,8'h00, 1'b0,1'b1,12'h000, 1'b0,1'b0,1'b0, 12'h3C3,4'h7, 4'hE, 1'b0,1'b1,1'b0,7'b0111100};
    vecs[7]  = '{1'b0,1'b1,8'h12, 1'b0,1'b0,12'h000, 1'b0,1'b0,1'b0, 12'h3C4,4'h1, 4'h2, 1'b1,1'b1,1'b0,7'b0001101};
    vecs[8]  = '{1'b0,1'b1,8'h00, 1'b1,1'b0,12'hFFF, 1'b1,1'b0,1'b1, 12'hFFF,4'h1, 4'h2, 1'b0,1'b0,1'b1,7'b0001010};
    vecs[9]  = '{1'b0,1'b1,8'hF0, 1'b0,1'b0,12'h000, 1'b0,1'b0,1'b0, 12'h000,4'hF, 4'h0, 1'b1,1'b0,1'b1,7'b1111011};
    vecs[10] = '{1'b0,1'b1,8'h00, 1'b0,1'b0,12'h000, 1'b0,1'b0,1'b0, 12'h000,4'hF, 4'h0, 1'b0,1'b0,1'b1,7'b1111010};
    vecs[11] = '{1'b0,1'b1,8'h5A, 1'b0,1'b0,12'h000, 1'b0,1'b0,1'b0, 12'h001,4'h5, 4'hA, 1'b1,1'b0,1'b1,7'b0101011};
    vecs[12] = '{1'b0,1'b1,8'h00, 1'b0,1'b1,12'hFFF, 1'b0,1'b0,1'b0, 12'h002,4'h5, 4'hA, 1'b0,1'b0,1'b1,7'b0101010};

    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].en, vecs[i].pb, vecs[i].lpc, vecs[i].ipc, vecs[i].la,
            vecs[i].fwe, vecs[i].ci, vecs[i].zi);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_op,
                vecs[i].e_ph, vecs[i].e_c, vecs[i].e_z, vecs[i].e_dec);
    end

    // Fetch 9C to land in EXEC at pc 003 with z set, then freeze.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h9C, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("fetch9c", 12'h003, 4'h9, 4'hC, 1'b1, 1'b0, 1'b1, 7'b1001011);

    // enable low for 5 cycles while inputs wiggle: nothing may move.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 8'(8'h31 * (k + 1)), k[0], ~k[0], 12'(12'h155 * (k + 1)),
            1'b1, ~k[0], k[1]);
      @(posedge clk);
      #1;
      check_all($sformatf("hold%0d", k), 12'h003, 4'h9, 4'hC, 1'b1, 1'b0, 1'b1, 7'b1001011);
    end

    // Reset while in EXEC with a jump and flag write pending: both discarded.
    @(negedge clk);
    drive(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 12'h555, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_all("rst_exec", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 7'b0000000);

    // First fetch after reset starts from pc 0.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("post_rst", 12'h001, 4'h6, 4'h1, 1'b1, 1'b0, 1'b0, 7'b0110001);

    // EXEC with inc only, then FETCH with flag write requested: flags stay clear.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("exec_inc", 12'h002, 4'h6, 4'h1, 1'b0, 1'b0, 1'b0, 7'b0110000);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hB4, 1'b1, 1'b1, 12'h777, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_all("fetch_ign", 12'h003, 4'hB, 4'h4, 1'b1, 1'b0, 1'b0, 7'b1011001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
